// File: rtl/arm_sequencer_if.sv
// Job and arm-side signal bundle for the pick-and-place sequencer.
// The slave modport is the sequencer; master is the command side / arm model.
interface arm_sequencer_if;
  logic        start;
  logic        abort;
  logic [31:0] pick_x;
  logic [31:0] pick_y;
  logic [31:0] place_x;
  logic [31:0] place_y;
  logic [31:0] x;
  logic [31:0] y;
  logic        en1;
  logic        en2;
  logic [31:0] set_xita1;
  logic [31:0] set_xita2;
  logic        catch;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [3:0]  state;

  modport slave (
    input  start, abort, pick_x, pick_y, place_x, place_y,
    output x, y, en1, en2, set_xita1, set_xita2, catch, busy, done, aborted, state
  );

  modport master (
    output start, abort, pick_x, pick_y, place_x, place_y,
    input  x, y, en1, en2, set_xita1, set_xita2, catch, busy, done, aborted, state
  );
endinterface

// File: rtl/arm_sequencer.sv
// Pick-and-place sequencer: drives the two-joint arm through
// home -> pick -> grip -> place -> release -> home with timed dwells.
//
// state      | meaning
// IDLE       | waiting for start, arm parked on preset angles
// HOME       | preset-angle mode, settling
// MOVE_PICK  | IK mode on pick coordinate, gripper open
// CLOSE      | IK mode on pick coordinate, gripper closing
// MOVE_PLACE | IK mode on place coordinate, gripper closed
// OPEN       | IK mode on place coordinate, gripper opening
// RETURN     | back to preset angles, gripper open
// DONE       | one-cycle job-complete pulse
module arm_sequencer #(
  parameter int unsigned SETTLE_CYC = 25_000_000,
  parameter int unsigned GRIP_CYC   = 15_000_000,
  parameter logic [31:0] HOME_XITA1 = 32'h005A_0000,
  parameter logic [31:0] HOME_XITA2 = 32'h005A_0000
) (
  input logic           clk,
  input logic           rst_n,
  arm_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    HOME       = 4'd1,
    MOVE_PICK  = 4'd2,
    CLOSE      = 4'd3,
    MOVE_PLACE = 4'd4,
    OPEN       = 4'd5,
    RETURN     = 4'd6,
    DONE       = 4'd7
  } state_t;

  localparam logic [24:0] SETTLE_LAST = 25'(SETTLE_CYC - 1);
  localparam logic [24:0] GRIP_LAST   = 25'(GRIP_CYC - 1);

  state_t      state_q;
  logic [24:0] cnt_q;
  logic [31:0] pick_x_q, pick_y_q, place_x_q, place_y_q;
  logic [31:0] x_q, y_q, xita1_q, xita2_q;
  logic        en1_q, en2_q, catch_q, busy_q, done_q, aborted_q;
  logic        dwell_end;

  always_comb begin
    dwell_end = 1'b0;
    if (state_q == CLOSE || state_q == OPEN) dwell_end = (cnt_q == GRIP_LAST);
    else                                     dwell_end = (cnt_q == SETTLE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pick_x_q  <= '0;
      pick_y_q  <= '0;
      place_x_q <= '0;
      place_y_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      xita1_q   <= HOME_XITA1;
      xita2_q   <= HOME_XITA2;
      en1_q     <= 1'b0;
      en2_q     <= 1'b1;
      catch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= HOME;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            aborted_q <= 1'b0;
            pick_x_q  <= bus.pick_x;
            pick_y_q  <= bus.pick_y;
            place_x_q <= bus.place_x;
            place_y_q <= bus.place_y;
          end
        end
        HOME, MOVE_PICK, CLOSE, MOVE_PLACE, OPEN: begin
          // abort outranks dwell expiry; the object is dropped on the way home
          if (bus.abort) begin
            state_q   <= RETURN;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
            catch_q   <= 1'b0;
            en1_q     <= 1'b0;
            en2_q     <= 1'b1;
          end else if (dwell_end) begin
            cnt_q <= '0;
            case (state_q)
              HOME: begin
                state_q <= MOVE_PICK;
                en1_q   <= 1'b1;
                en2_q   <= 1'b0;
                x_q     <= pick_x_q;
                y_q     <= pick_y_q;
              end
              MOVE_PICK: begin
                state_q <= CLOSE;
                catch_q <= 1'b1;
              end
              CLOSE: begin
                state_q <= MOVE_PLACE;
                x_q     <= place_x_q;
                y_q     <= place_y_q;
              end
              MOVE_PLACE: begin
                state_q <= OPEN;
                catch_q <= 1'b0;
              end
              default: begin
                state_q <= RETURN;
                en1_q   <= 1'b0;
                en2_q   <= 1'b1;
              end
            endcase
          end else begin
            cnt_q <= cnt_q + 25'd1;
          end
        end
        RETURN: begin
          if (dwell_end) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 25'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          en1_q   <= 1'b0;
          en2_q   <= 1'b1;
          catch_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.en1       = en1_q;
  assign bus.en2       = en2_q;
  assign bus.catch     = catch_q;
  assign bus.set_xita1 = xita1_q;
  assign bus.set_xita2 = xita2_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_arm_sequencer.sv
// Randomized bench for arm_sequencer: a queue of expected per-cycle output
// records is built for each job and compared against the DUT every cycle.
module tb_arm_sequencer;

  localparam int          SETTLE = 8;
  localparam int          GRIP   = 4;
  localparam logic [31:0] XITA1  = 32'h005A_0000;
  localparam logic [31:0] XITA2  = 32'h002D_0000;

  logic clk;
  logic rst_n;
  arm_sequencer_if bus();

  arm_sequencer #(
    .SETTLE_CYC(SETTLE),
    .GRIP_CYC  (GRIP),
    .HOME_XITA1(XITA1),
    .HOME_XITA2(XITA2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  st;
    logic        en1;
    logic        en2;
    logic        cat;
    logic [31:0] x;
    logic [31:0] y;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  logic m_aborted;

  function automatic rec_t mk(input logic [3:0] st, input logic e1, input logic e2,
                              input logic c, input logic [31:0] xx, input logic [31:0] yy);
    rec_t r;
    r.st = st; r.en1 = e1; r.en2 = e2; r.cat = c; r.x = xx; r.y = yy;
    return r;
  endfunction

  task automatic push_n(input rec_t r, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(r);
  endtask

  // Reference: a job is a fixed list of (outputs, duration) steps; abort
  // replaces whatever remains with the return-home tail.
  task automatic model_step();
    logic [31:0] px, py, qx, qy;
    if (cur.st == 4'd0) begin
      if (bus.start) begin
        px = bus.pick_x; py = bus.pick_y; qx = bus.place_x; qy = bus.place_y;
        m_aborted = 1'b0;
        push_n(mk(4'd1, 1'b0, 1'b1, 1'b0, cur.x, cur.y), SETTLE);
        push_n(mk(4'd2, 1'b1, 1'b0, 1'b0, px, py), SETTLE);
        push_n(mk(4'd3, 1'b1, 1'b0, 1'b1, px, py), GRIP);
        push_n(mk(4'd4, 1'b1, 1'b0, 1'b1, qx, qy), SETTLE);
        push_n(mk(4'd5, 1'b1, 1'b0, 1'b0, qx, qy), GRIP);
        push_n(mk(4'd6, 1'b0, 1'b1, 1'b0, qx, qy), SETTLE);
        push_n(mk(4'd7, 1'b0, 1'b1, 1'b0, qx, qy), 1);
        cur = exp_q.pop_front();
      end
    end else if (bus.abort && cur.st >= 4'd1 && cur.st <= 4'd5) begin
      exp_q.delete();
      push_n(mk(4'd6, 1'b0, 1'b1, 1'b0, cur.x, cur.y), SETTLE);
      push_n(mk(4'd7, 1'b0, 1'b1, 1'b0, cur.x, cur.y), 1);
      cur = exp_q.pop_front();
      m_aborted = 1'b1;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = mk(4'd0, 1'b0, 1'b1, 1'b0, cur.x, cur.y);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      cur = mk(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
      m_aborted = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic check_all();
    chk("state",   32'(bus.state),   32'(cur.st));
    chk("x",       bus.x,            cur.x);
    chk("y",       bus.y,            cur.y);
    chk("en1",     32'(bus.en1),     32'(cur.en1));
    chk("en2",     32'(bus.en2),     32'(cur.en2));
    chk("catch",   32'(bus.catch),   32'(cur.cat));
    chk("busy",    32'(bus.busy),    32'(cur.st != 4'd0));
    chk("done",    32'(bus.done),    32'(cur.st == 4'd7));
    chk("aborted", 32'(bus.aborted), 32'(m_aborted));
    chk("xita1",   bus.set_xita1,    XITA1);
    chk("xita2",   bus.set_xita2,    XITA2);
    chk("en_excl", 32'(bus.en1 & bus.en2), 32'd0);
  endtask

  always @(negedge clk) check_all();

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", 32'(bus.state), 32'(s));
  endtask

  task automatic launch(input logic [31:0] px, input logic [31:0] py,
                        input logic [31:0] qx, input logic [31:0] qy);
    @(negedge clk);
    bus.pick_x = px; bus.pick_y = py; bus.place_x = qx; bus.place_y = qy;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pick_x = '0; bus.pick_y = '0; bus.place_x = '0; bus.place_y = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // nominal job, latency from start edge to done
    launch(32'h000A_0000, 32'h0005_0000, 32'h0010_0000, 32'h0);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", 32'(n), 32'd40);
    wait_state(4'd0, 10);

    // abort in the second cycle of CLOSE
    launch(32'h000A_0000, 32'h0005_0000, 32'h0010_0000, 32'h0);
    wait_state(4'd3, 100);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_state", 32'(bus.state), 32'd6);
    chk("abort_catch", 32'(bus.catch), 32'd0);
    repeat (SETTLE) @(negedge clk);
    chk("abort_done", 32'(bus.done), 32'd1);
    chk("abort_flag", 32'(bus.aborted), 32'd1);
    wait_state(4'd0, 10);

    // start held high, coordinates churning mid-job
    bus.start = 1'b1;
    repeat (3 * 42) begin
      @(negedge clk);
      bus.pick_x = $urandom; bus.pick_y = $urandom;
      bus.place_x = $urandom; bus.place_y = $urandom;
    end
    bus.start = 1'b0;
    wait_state(4'd0, 100);

    // start and abort together, abort held
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("home_entry", 32'(bus.state), 32'd1);
    @(negedge clk);
    chk("home_cut", 32'(bus.state), 32'd6);
    repeat (12) @(negedge clk);
    bus.abort = 1'b0;
    wait_state(4'd0, 20);

    // asynchronous reset in MOVE_PLACE
    launch($urandom, $urandom, $urandom, $urandom);
    wait_state(4'd4, 100);
    #2 rst_n = 1'b0;
    #1 check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    repeat (800) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 9) == 0);
      bus.abort = ($urandom_range(0, 39) == 0);
      bus.pick_x = $urandom; bus.pick_y = $urandom;
      bus.place_x = $urandom; bus.place_y = $urandom;
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    wait_state(4'd0, 100);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arm_sequencer.md
# arm_sequencer

Pick-and-place sequencer for the two-joint arm. It accepts one job at a time: a pick coordinate and a place coordinate, in Q16.16 cm relative to joint 1. It drives the arm's coordinate, enable, preset-angle and gripper inputs through home → pick → grip → place → release → home, holding each step for a programmable settle time. It sits between the task-level logic (UART/keypad command decoder) and the arm datapath. It owns the arm's `x`, `y`, `en1`, `en2`, `set_xita1`, `set_xita2` and `catch` inputs exclusively.

## Interface
Parameters:
- `SETTLE_CYC`, default 25_000_000: cycles spent in each motion state (0.5 s at 50 MHz); legal range ≥ 1.
- `GRIP_CYC`, default 15_000_000: cycles spent in each gripper state; legal range ≥ 1.
- `HOME_XITA1`, default 32'h005A_0000: joint-1 home angle, Q16.16 degrees (90°).
- `HOME_XITA2`, default 32'h005A_0000: joint-2 home angle, Q16.16 degrees (90°).

Ports:
- `clk`  in  1  50 MHz clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level; accepted only in IDLE.
- `abort`  in  1  level; sampled every cycle.
- `pick_x`, `pick_y`  in  32  pick coordinate, Q16.16; sampled on accepted start.
- `place_x`, `place_y`  in  32  place coordinate, Q16.16; sampled on accepted start.
- `x`, `y`  out  32  coordinate to arm.
- `en1`  out  1  inverse-kinematics enable to arm.
- `en2`  out  1  preset-angle enable to arm.
- `set_xita1`, `set_xita2`  out  32  preset angles; constant HOME_XITA1/HOME_XITA2.
- `catch`  out  1  gripper close.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `aborted`  out  1  set when a job is aborted; cleared on the next accepted start.
- `state`  out  4  current state code, for debug.

## Operation
- FSM states and codes: IDLE=0, HOME=1, MOVE_PICK=2, CLOSE=3, MOVE_PLACE=4, OPEN=5, RETURN=6, DONE=7.
- Every output is a register.
- Reset values:
  - `state`=IDLE; `x`=`y`=0; `en1`=0; `en2`=1; `catch`=0.
  - `busy`=0; `done`=0; `aborted`=0; counter=0.
  - `set_xita1`/`set_xita2`=HOME values.
  - Registered pick/place latches=0.
- Outputs per state:
  - IDLE, HOME, RETURN: `en2`=1, `en1`=0, `catch`=0; `x`/`y` hold their last value.
  - MOVE_PICK: `en1`=1, `en2`=0, `x`/`y`=latched pick, `catch`=0.
  - CLOSE: same as MOVE_PICK but `catch`=1.
  - MOVE_PLACE: `en1`=1, `en2`=0, `x`/`y`=latched place, `catch`=1.
  - OPEN: same as MOVE_PLACE but `catch`=0.
  - DONE: same outputs as RETURN, plus `done`=1.
- `en1` and `en2` are never both 1.
- Transitions:
  - IDLE→HOME on `start`=1. The same edge latches pick/place and clears `aborted`.
  - HOME→MOVE_PICK→CLOSE→MOVE_PLACE→OPEN→RETURN→DONE, each on dwell expiry.
  - DONE→IDLE unconditionally after one cycle.
- Dwell:
  - A 25-bit counter clears on state entry and increments each cycle.
  - The state exits on the edge where counter == N−1.
  - N = SETTLE_CYC for HOME, MOVE_PICK, MOVE_PLACE, RETURN; N = GRIP_CYC for CLOSE, OPEN.
  - Each state therefore lasts exactly N cycles.
- Abort:
  - `abort`=1 in HOME through OPEN → next state RETURN, counter cleared, `aborted`←1, `catch`←0 (the object is dropped).
  - `abort` in IDLE, RETURN or DONE is ignored.
- Simultaneous events:
  - `start` and `abort` together in IDLE: start is accepted, abort is ignored.
  - `abort` coinciding with dwell expiry: abort wins.
- `start` while busy is ignored. No job is queued; a `start` held high through DONE launches a new job from IDLE.
- Coordinate changes on `pick_*`/`place_*` while busy have no effect.
- Reset mid-job: the block returns immediately to reset values, with no DONE pulse.

## Timing
- Accepted start at edge k:
  - `busy`=1 and `state`=HOME visible after edge k.
  - `en2`=1 throughout HOME.
- First MOVE_PICK output cycle follows edge k+SETTLE_CYC.
- Full job length from edge k: `done` is high in the cycle after edge k+4·SETTLE_CYC+2·GRIP_CYC. `busy` falls one cycle later.
- Abort sampled at edge m:
  - `state`=RETURN and `catch`=0 after edge m.
  - `done` is high after edge m+SETTLE_CYC.
- Back-to-back jobs: minimum one IDLE cycle between DONE and the next HOME.

## Test plan
- Reset with SETTLE_CYC=8, GRIP_CYC=4: check all reset values, `en2`=1, `state`=0. Assert `start` with pick=(0x000A_0000, 0x0005_0000) and place=(0x0010_0000, 0).
  - `state` sequence 1,2,3,4,5,6,7 with dwells 8,8,4,8,4,8,1.
  - `done` pulses exactly once, 40 cycles after the start edge.
  - `x`/`y` equal pick in states 2–3 and place in states 4–5.
- Same job, `abort` pulsed for 1 cycle in the 2nd cycle of CLOSE:
  - next `state`=6 and `catch`=0;
  - 8 cycles later `done`=1 and `aborted`=1;
  - the next start clears `aborted`.
- `start` held high continuously: jobs repeat, separated by exactly one IDLE cycle. Pick/place changes mid-job do not alter `x`/`y` until the next HOME.
- `abort` and `start` high together in IDLE: the job starts. `abort` held high thereafter: HOME is cut to 1 cycle, then RETURN runs its full 8 cycles.
- `rst_n` low during MOVE_PLACE: outputs return to reset values asynchronously, and no `done` pulse occurs.
- Throughout all scenarios, assert `en1`&`en2` is never 1.
